// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage 16-bit pipeline: forwarding, load-use stall,
// branch flush and halt drain. Optional perf counters enabled by HAZARD_PERF_CNT_EN.
//
// state   | meaning
// S_RUN   | normal issue; stalls, flushes and halt acceptance evaluated
// S_DRAIN | halt accepted; bubbles issued while older instructions retire
// S_HALTED| pipeline empty, PC frozen until resume
module pipeline_hazard_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_AW       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst1,
    input  logic              ex_branch_taken,
    input  logic              mem_reg_write,
    input  logic              mem_write_op2,
    input  logic [REG_AW-1:0] mem_dst1,
    input  logic [REG_AW-1:0] mem_dst2,
    input  logic              wb_reg_write,
    input  logic              wb_write_op2,
    input  logic [REG_AW-1:0] wb_dst1,
    input  logic [REG_AW-1:0] wb_dst2,
    input  logic              resume,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic              halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
`endif
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] drain_cnt, drain_cnt_nxt;
    logic       load_use;

    // MEM beats WB; within a stage the high-half write beats the low-half write
    function automatic logic [2:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              m_lo, input logic m_hi,
        input logic [REG_AW-1:0] m_d1, input logic [REG_AW-1:0] m_d2,
        input logic              w_lo, input logic w_hi,
        input logic [REG_AW-1:0] w_d1, input logic [REG_AW-1:0] w_d2
    );
        if (m_hi && m_d2 == src)      return 3'd2;
        else if (m_lo && m_d1 == src) return 3'd1;
        else if (w_hi && w_d2 == src) return 3'd4;
        else if (w_lo && w_d1 == src) return 3'd3;
        else                          return 3'd0;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_write_op2, mem_dst1, mem_dst2,
                           wb_reg_write, wb_write_op2, wb_dst1, wb_dst2);
    assign fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_write_op2, mem_dst1, mem_dst2,
                           wb_reg_write, wb_write_op2, wb_dst1, wb_dst2);

    assign load_use = ex_mem_read &&
                      ((id_uses_rs1 && id_rs1 == ex_dst1) || (id_uses_rs2 && id_rs2 == ex_dst1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            drain_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        halted        = 1'b0;
        case (state)
            S_RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_halt) begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    idex_bubble   = 1'b1;
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                if (drain_cnt == 3'd0) state_nxt = S_HALTED;
                else                   drain_cnt_nxt = drain_cnt - 3'd1;
            end
            S_HALTED: begin
                halted      = 1'b1;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                // flush on the leaving edge so the halt sitting in IF/ID never re-issues
                if (resume) begin
                    ifid_flush = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stall_evt, flush_evt;

    assign stall_evt = (state == S_RUN) && load_use && !ex_branch_taken;
    assign flush_evt = (state == S_RUN) && ex_branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (stall_evt && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            if (flush_evt && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
